// File: rtl/mp2_mem_if.sv
// CPU memory handshake bundle: request side driven by the initiator,
// mem_resp/mem_rdata driven by the memory responder.
interface mp2_mem_if;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic        mem_resp;
    logic [31:0] mem_rdata;

    modport master (
        output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        input  mem_resp, mem_rdata
    );

    modport slave (
        input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        output mem_resp, mem_rdata
    );
endinterface

// File: rtl/mp2_mem_responder.sv
// Word-organised RAM answering the CPU memory handshake after a fixed latency,
// with a sticky flag for initiator protocol violations.
module mp2_mem_responder #(
    parameter int unsigned ADDR_BITS = 10,
    parameter int unsigned LATENCY   = 3
) (
    input  logic      clk,
    input  logic      rst,
    mp2_mem_if.slave  bus,
    output logic      proto_err_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } state_e;

    localparam int unsigned WORDS = 2 ** ADDR_BITS;
    // BUSY spans LATENCY-1 cycles, so the counter starts at LATENCY-2 and exits on zero.
    localparam logic [3:0] CNT_LOAD = 4'((LATENCY >= 2) ? LATENCY - 2 : 0);

    state_e                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   op_rd_q, op_wr_q;
    logic [31:0]            addr_q;
    logic [3:0]             be_q;
    logic [31:0]            wdata_q;
    logic [31:0]            rdata_q;
    logic                   err_q, err_d;
    logic [31:0]            ram_q [WORDS];

    logic                   req;
    logic                   accept;
    logic                   commit;
    logic                   c_wr;
    logic [ADDR_BITS-1:0]   c_idx;
    logic [3:0]             c_be;
    logic [31:0]            c_wdata;
    logic                   resp;

    assign req    = bus.mem_read | bus.mem_write;
    assign accept = (state_q == ST_IDLE) && req;

    // ---------------------------------------------------------------- FSM
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = (LATENCY == 1) ? ST_RESP : ST_BUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        resp = 1'b0;
        if (state_q == ST_RESP) begin
            resp = 1'b1;
        end
    end

    // ------------------------------------------------------ commit select
    // With LATENCY==1 the commit edge is also the acceptance edge, so take the bus directly.
    always_comb begin
        if (state_q == ST_IDLE) begin
            c_wr    = bus.mem_write;
            c_idx   = bus.mem_address[ADDR_BITS+1:2];
            c_be    = bus.mem_byte_enable;
            c_wdata = bus.mem_wdata;
        end else begin
            c_wr    = op_wr_q;
            c_idx   = addr_q[ADDR_BITS+1:2];
            c_be    = be_q;
            c_wdata = wdata_q;
        end
    end

    assign commit = (state_d == ST_RESP) && (state_q != ST_RESP) && !rst;

    // ------------------------------------------------------ protocol check
    always_comb begin
        err_d = err_q;
        if (state_q == ST_IDLE && bus.mem_read && bus.mem_write) begin
            err_d = 1'b1;
        end
        if (state_q == ST_BUSY) begin
            if (!req) begin
                err_d = 1'b1;
            end else if (bus.mem_address != addr_q  ||
                         bus.mem_read    != op_rd_q ||
                         bus.mem_write   != op_wr_q ||
                         (op_wr_q && bus.mem_wdata != wdata_q)) begin
                err_d = 1'b1;
            end
        end
    end

    // ------------------------------------------------------- request latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_rd_q <= 1'b0;
            op_wr_q <= 1'b0;
            addr_q  <= 32'd0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            err_q <= err_d;
            if (accept) begin
                op_rd_q <= bus.mem_read;
                op_wr_q <= bus.mem_write;
                addr_q  <= bus.mem_address;
                be_q    <= bus.mem_byte_enable;
                wdata_q <= bus.mem_wdata;
            end
            if (commit && !c_wr) begin
                rdata_q <= ram_q[c_idx];
            end
        end
    end

    // ------------------------------------------------------------- storage
    // NOTE: the RAM array has no reset so it maps onto block RAM; contents survive rst.
    always_ff @(posedge clk) begin
        if (commit && c_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (c_be[b]) begin
                    ram_q[c_idx][8*b +: 8] <= c_wdata[8*b +: 8];
                end
            end
        end
    end

    assign bus.mem_resp  = resp;
    assign bus.mem_rdata = rdata_q;
    assign proto_err_o   = err_q;

endmodule

// File: tb/tb_mp2_mem_responder.sv
// Self-checking bench: directed protocol scenarios plus a randomized read/write
// mix on a LATENCY=3 responder, and back-to-back reads on a LATENCY=1 responder.
module tb_mp2_mem_responder;

    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst;
    logic perr3, perr1;

    always #5 clk = ~clk;

    mp2_mem_if m3 ();
    mp2_mem_if m1 ();

    mp2_mem_responder #(.ADDR_BITS(10), .LATENCY(LAT)) dut3 (
        .clk         (clk),
        .rst         (rst),
        .bus         (m3.slave),
        .proto_err_o (perr3)
    );

    mp2_mem_responder #(.ADDR_BITS(10), .LATENCY(1)) dut1 (
        .clk         (clk),
        .rst         (rst),
        .bus         (m1.slave),
        .proto_err_o (perr1)
    );

    // Reference model: plain word array indexed by address bits [11:2].
    logic [31:0] mdl [1024];
    logic [31:0] last_rd;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] addr);
        return int'(addr[11:2]);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    task automatic drive3(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wd);
        m3.mem_read        = rd;
        m3.mem_write       = wr;
        m3.mem_address     = addr;
        m3.mem_byte_enable = be;
        m3.mem_wdata       = wd;
    endtask

    task automatic idle3();
        drive3(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    endtask

    // Full transaction on the LATENCY=3 responder, started at a negedge.
    // Checks resp is low before T+LAT, high at T+LAT, low again at T+LAT+1.
    task automatic txn3(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd, input string tag);
        logic [31:0] exp_rd;
        drive3(rd, wr, addr, be, wd);
        if (wr) begin
            mdl[widx(addr)] = merge(mdl[widx(addr)], wd, be);
        end else begin
            last_rd = mdl[widx(addr)];
        end
        exp_rd = last_rd;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            check({tag, "_resp"}, {31'd0, m3.mem_resp}, {31'd0, (k == LAT)});
        end
        check({tag, "_rdata"}, m3.mem_rdata, exp_rd);
        idle3();
        @(negedge clk);
        check({tag, "_resp_end"}, {31'd0, m3.mem_resp}, 32'd0);
    endtask

    initial begin
        logic [9:0]  pool [8];
        logic [31:0] a, d;
        logic [3:0]  be;
        int          pulses;

        rst = 1'b1;
        idle3();
        m1.mem_read = 1'b0; m1.mem_write = 1'b0; m1.mem_byte_enable = 4'd0;
        m1.mem_address = 32'd0; m1.mem_wdata = 32'd0;
        last_rd = 32'd0;
        #1;
        check("rst_resp",  {31'd0, m3.mem_resp}, 32'd0);
        check("rst_rdata", m3.mem_rdata, 32'd0);
        check("rst_perr",  {31'd0, perr3}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Known prior contents for the reset-abort scenario.
        txn3(1'b0, 1'b1, 32'h40, 4'hF, 32'h01020304, "init40");

        // Address/data changed mid-BUSY: latched values win, error flagged.
        drive3(1'b0, 1'b1, 32'h60, 4'hF, 32'h77);
        mdl[widx(32'h60)] = 32'h77;
        @(negedge clk);
        drive3(1'b0, 1'b1, 32'h64, 4'hF, 32'h99);
        @(negedge clk);
        check("chg_resp_t2", {31'd0, m3.mem_resp}, 32'd0);
        @(negedge clk);
        check("chg_resp_t3", {31'd0, m3.mem_resp}, 32'd1);
        check("chg_perr",    {31'd0, perr3}, 32'd1);
        idle3();
        @(negedge clk);
        txn3(1'b1, 1'b0, 32'h60, 4'hF, 32'h0, "chg_rd60");

        // Reset in the middle of a write: dropped, outputs and flag cleared at once.
        drive3(1'b0, 1'b1, 32'h40, 4'hF, 32'hDEADBEEF);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_resp",  {31'd0, m3.mem_resp}, 32'd0);
        check("abort_perr",  {31'd0, perr3}, 32'd0);
        check("abort_rdata", m3.mem_rdata, 32'd0);
        idle3();
        last_rd = 32'd0;
        @(negedge clk);
        rst = 1'b0;
        txn3(1'b1, 1'b0, 32'h40, 4'hF, 32'h0, "abort_rd40");

        // Latency and throughput: read accepted at T+4 after a write at T.
        txn3(1'b0, 1'b1, 32'h100, 4'hF, 32'h12345678, "lat_wr");
        txn3(1'b1, 1'b0, 32'h100, 4'h0, 32'h0, "lat_rd");

        // Byte lanes.
        txn3(1'b0, 1'b1, 32'h8, 4'hF,    32'h11223344, "lane_init");
        txn3(1'b0, 1'b1, 32'h8, 4'b0101, 32'hAABBCCDD, "lane_wr");
        txn3(1'b1, 1'b0, 32'h8, 4'hF,    32'h0, "lane_rd");

        // Aliasing through ignored address bits.
        txn3(1'b0, 1'b1, 32'h0000_0004, 4'hF, 32'hCAFEF00D, "alias_wr");
        txn3(1'b1, 1'b0, 32'h0000_1006, 4'h0, 32'h0, "alias_rd");
        check("alias_perr", {31'd0, perr3}, 32'd0);

        // Randomized mix over a small pool of words, including aliased addresses.
        for (int i = 0; i < 8; i++) begin
            pool[i] = 10'($urandom_range(16, 1023));
            txn3(1'b0, 1'b1, {20'($urandom), pool[i], 2'($urandom)}, 4'hF, $urandom, "rnd_init");
        end
        for (int i = 0; i < 30; i++) begin
            a  = {20'($urandom), pool[$urandom_range(0, 7)], 2'($urandom)};
            d  = $urandom;
            be = 4'($urandom);
            if ($urandom_range(0, 1) == 1) txn3(1'b0, 1'b1, a, be, d, "rnd_wr");
            else                           txn3(1'b1, 1'b0, a, be, d, "rnd_rd");
        end
        // Zero-enable write changes nothing.
        txn3(1'b0, 1'b1, 32'h8, 4'b0000, 32'hFFFFFFFF, "be0_wr");
        txn3(1'b1, 1'b0, 32'h8, 4'hF, 32'h0, "be0_rd");
        check("rnd_perr", {31'd0, perr3}, 32'd0);

        // Read and write together: treated as a write, flagged.
        txn3(1'b1, 1'b1, 32'h20, 4'hF, 32'h5, "both_wr");
        check("both_perr", {31'd0, perr3}, 32'd1);
        txn3(1'b1, 1'b0, 32'h20, 4'hF, 32'h0, "both_rd");

        // Request dropped mid-BUSY: still completes.
        drive3(1'b1, 1'b0, 32'h20, 4'hF, 32'h0);
        @(negedge clk);
        idle3();
        @(negedge clk);
        check("drop_resp_t2", {31'd0, m3.mem_resp}, 32'd0);
        @(negedge clk);
        check("drop_resp_t3", {31'd0, m3.mem_resp}, 32'd1);
        check("drop_rdata",   m3.mem_rdata, mdl[widx(32'h20)]);
        check("drop_perr",    {31'd0, perr3}, 32'd1);
        @(negedge clk);
        check("drop_resp_end", {31'd0, m3.mem_resp}, 32'd0);

        // LATENCY=1 responder: one write, then a read held for six cycles.
        m1.mem_write = 1'b1; m1.mem_byte_enable = 4'hF;
        m1.mem_address = 32'h0; m1.mem_wdata = 32'h13579BDF;
        @(negedge clk);
        check("l1_wr_resp", {31'd0, m1.mem_resp}, 32'd1);
        m1.mem_write = 1'b0; m1.mem_wdata = 32'd0;
        @(negedge clk);
        check("l1_wr_idle", {31'd0, m1.mem_resp}, 32'd0);
        m1.mem_read = 1'b1;
        pulses = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check("l1_rd_resp", {31'd0, m1.mem_resp}, {31'd0, (k % 2 == 1)});
            if (m1.mem_resp === 1'b1) begin
                pulses++;
                check("l1_rd_rdata", m1.mem_rdata, 32'h13579BDF);
            end
        end
        m1.mem_read = 1'b0;
        check("l1_pulses", 32'(pulses), 32'd3);
        check("l1_perr",   {31'd0, perr1}, 32'd0);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
